// File: rtl/large_xor_arb_if.sv
// Handshake and data bundle between two operand requesters, the shared XOR
// arbiter and the result consumer.
interface large_xor_arb_if #(
    parameter int WIDTH = 13,
    parameter int CNTW  = 8
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             out_zero;
    logic [CNTW-1:0]  cnt0;
    logic [CNTW-1:0]  cnt1;

    modport master (
        output req_valid, a0, b0, a1, b1, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_zero, cnt0, cnt1
    );

    modport slave (
        input  req_valid, a0, b0, a1, b1, out_ready,
        output req_ready, out_valid, out_data, out_id, out_zero, cnt0, cnt1
    );
endinterface

// File: rtl/large_xor_arb.sv
// Two requesters share one XOR unit under round-robin arbitration; the result
// sits in a one-entry output register, and completions are counted per requester.
module large_xor_arb #(
    parameter int WIDTH = 13,
    parameter int CNTW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    large_xor_arb_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_id_q, out_id_d;
    logic             out_zero_q, out_zero_d;
    logic             rr_last_q, rr_last_d;
    logic [CNTW-1:0]  cnt0_q, cnt0_d;
    logic [CNTW-1:0]  cnt1_q, cnt1_d;

    logic             free;
    logic             grant_valid;
    logic             grant_id;
    logic             transfer;
    logic             handshake;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // A tie goes to whichever requester did not win last; reset gates every grant.
    always_comb begin
        grant_valid = (bus.req_valid != 2'b00);
        grant_id    = 1'b0;
        if (bus.req_valid == 2'b11) begin
            grant_id = ~rr_last_q;
        end else if (bus.req_valid[1]) begin
            grant_id = 1'b1;
        end
        free     = (state_q == EMPTY) || bus.out_ready;
        transfer = rst_n && free && grant_valid;
        bus.req_ready = 2'b00;
        if (transfer) begin
            bus.req_ready = grant_id ? 2'b10 : 2'b01;
        end
        op_a = grant_id ? bus.a1 : bus.a0;
        op_b = grant_id ? bus.b1 : bus.b0;
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        out_zero_d = out_zero_q;
        rr_last_d  = rr_last_q;
        if (transfer) begin
            state_d    = FULL;
            out_data_d = op_a ^ op_b;
            out_id_d   = grant_id;
            out_zero_d = (op_a == op_b);
            rr_last_d  = grant_id;
        end else if (free) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        handshake = (state_q == FULL) && bus.out_ready;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        if (handshake) begin
            if (out_id_q) begin
                cnt1_d = cnt1_q + CNTW'(1);
            end else begin
                cnt0_d = cnt0_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_id_q   <= 1'b0;
            out_zero_q <= 1'b0;
            rr_last_q  <= 1'b1;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            out_zero_q <= out_zero_d;
            rr_last_q  <= rr_last_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.cnt0      = cnt0_q;
    assign bus.cnt1      = cnt1_q;
endmodule
